instr_fetch_unit: RTL and testbench

//   Fetch stage feeding the single-cycle MIPS decode/execute logic (mainDecoder, AluDecoder, SignExtender).

---
 rtl/instr_fetch_unit.sv | 90 +++++++++
 tb/tb_instr_fetch_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the single-cycle MIPS core: owns the PC, fetches over a req/ack
// handshake, holds the instruction through execute and counts retired instructions.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [31:0] signimm,
  input  logic        exec_done,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] next_pc;
  logic        take_ack, take_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr   <= '0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (take_ack)
        instr <= imem_rdata;
      if (take_done) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    take_ack    = 1'b0;
    take_done   = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          take_ack  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          take_done = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Jump outranks a taken branch.
  always_comb begin
    if (jump)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && zero)
      next_pc = pc_plus4 + (signimm << 2);
    else
      next_pc = pc_plus4;
  end

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential flow, branch, jump, wait states,
// PC wrap and mid-fetch reset, checked with immediate assertions.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [31:0] signimm;
  logic        exec_done;
  logic [31:0] retired;

  int n_assert = 0;
  int n_fail   = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .branch(branch), .zero(zero), .jump(jump), .signimm(signimm),
    .exec_done(exec_done), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in FETCH at address a; acks d at once, executes with the given controls,
  // and ends back in FETCH checking the new address and retired count.
  task automatic fetch_exec(input logic [31:0] a, input logic [31:0] d,
                            input logic br, input logic z, input logic j,
                            input logic [31:0] simm, input logic [31:0] nxt,
                            input logic [31:0] ret);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, a);
    chk("fetch_nvalid", {31'd0, instr_valid}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = d;
    tick();
    imem_ack = 1'b0;
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("exec_nreq", {31'd0, imem_req}, 32'd0);
    chk("exec_instr", instr, d);
    chk("exec_pc", pc, a);
    chk("exec_pc4", pc_plus4, a + 32'd4);
    branch     = br;
    zero       = z;
    jump       = j;
    signimm    = simm;
    exec_done  = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    exec_done = 1'b0;
    imem_ack  = 1'b0;
    branch    = 1'b0;
    zero      = 1'b0;
    jump      = 1'b0;
    signimm   = 32'h0;
    chk("next_addr", imem_addr, nxt);
    chk("next_req", {31'd0, imem_req}, 32'd1);
    chk("retired", retired, ret);
    chk("instr_hold", instr, d);
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    branch = 1'b0; zero = 1'b0; jump = 1'b0; signimm = 32'h0; exec_done = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_retired", retired, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick();

    // Sequential run, then jump to 0x100
    fetch_exec(32'h0000_0000, 32'h2008_0001, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 32'd1);
    fetch_exec(32'h0000_0004, 32'h2009_0002, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0008, 32'd2);
    fetch_exec(32'h0000_0008, 32'h012A_5820, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_000C, 32'd3);
    fetch_exec(32'h0000_000C, 32'h0800_0040, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0100, 32'd4);

    // Branch taken backwards, then not taken
    fetch_exec(32'h0000_0100, 32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_00FC, 32'd5);
    fetch_exec(32'h0000_00FC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0100, 32'd6);
    fetch_exec(32'h0000_0100, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0104, 32'd7);

    // Far branch to 0x1000_0010, then jump with branch also asserted
    fetch_exec(32'h0000_0104, 32'h1000_FFC2, 1'b1, 1'b1, 1'b0, 32'h03FF_FFC2, 32'h1000_0010, 32'd8);
    fetch_exec(32'h1000_0010, 32'h0800_0040, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h1000_0100, 32'd9);

    // Five memory wait states with a spurious exec_done
    for (int i = 0; i < 5; i++) begin
      exec_done = 1'b1;
      tick();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h1000_0100);
      chk("wait_nvalid", {31'd0, instr_valid}, 32'd0);
      chk("wait_retired", retired, 32'd9);
      chk("wait_instr", instr, 32'h0800_0040);
    end
    exec_done = 1'b0;

    // Branch to 0xFFFF_FFFC, then wrap to 0
    fetch_exec(32'h1000_0100, 32'h1000_FFBE, 1'b1, 1'b1, 1'b0, 32'h3BFF_FFBE, 32'hFFFF_FFFC, 32'd10);
    fetch_exec(32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'd11);
    fetch_exec(32'h0000_0000, 32'h2008_0001, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 32'd12);

    // Reset while a request is outstanding
    tick();
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    reset      = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_retired", retired, 32'h0);
    chk("mid_rst_instr", instr, 32'h0);
    tick();
    reset = 1'b0;
    chk("post_rst_idle", {31'd0, imem_req}, 32'd0);
    tick();
    imem_ack = 1'b0;
    chk("post_rst_fetch", {31'd0, imem_req}, 32'd1);
    chk("post_rst_nvalid", {31'd0, instr_valid}, 32'd0);
    chk("post_rst_instr", instr, 32'h0);
    chk("post_rst_addr", imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
